// File: rtl/mult_sequencer.sv
// Shift-add unsigned WIDTHxWIDTH->2*WIDTH multiplier driving a shared external adder, one iteration per clock.
// Latency WIDTH cycles from accepted start to done; starts while busy are dropped (no queueing).
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] add_op1,
  output logic [WIDTH-1:0] add_op2,
  input  logic [WIDTH-1:0] add_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry;

  assign add_op1 = hi_q;
  assign add_op2 = (state_q == S_RUN && lo_q[0]) ? mcand_q : '0;

  // The shared adder has no carry-out; a wrapped sum is smaller than either operand.
  assign carry = (add_out < add_op1);

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          mcand_d = op_a;
          hi_d    = '0;
          lo_d    = op_b;
          count_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        hi_d = {carry, add_out[WIDTH-1:1]};
        lo_d = {add_out[0], lo_q[WIDTH-1:1]};
        if (count_q == LAST) begin
          state_d = S_DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: directed vector table, protocol corner cases, and random operands vs. a 64-bit product model.
module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] hi, lo, add_op1, add_op2, add_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the core's shared adder.
  assign add_out = add_op1 + add_op2;

  mult_sequencer #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .add_op1 (add_op1),
    .add_op2 (add_op2),
    .add_out (add_out)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge where busy has dropped.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input bit poke, output int lat);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    lat   = 0;
    while (busy && lat < 64) begin
      lat++;
      start = poke && (lat == 5 || lat == 20);
      if (start) begin
        op_a = $urandom;
        op_b = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic finish_checks(input string name, input int lat, input logic [63:0] exp);
    chk({name, ".latency"}, 64'(lat), 64'd32);
    chk({name, ".done"}, 64'(done), 64'd1);
    chk({name, ".product"}, {hi, lo}, exp);
  endtask

  task automatic hold_checks(input string name, input logic [63:0] exp);
    @(negedge clk);
    chk({name, ".done_drop"}, {62'd0, busy, done}, 64'd0);
    chk({name, ".hold"}, {hi, lo}, exp);
  endtask

  initial begin
    int lat;
    int done_cnt;
    logic [31:0] ra, rb;
    logic [63:0] exp;

    vecs[0] = '{a: 32'd3,          b: 32'd5,          exp_hi: 32'h0000_0000, exp_lo: 32'h0000_000F};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  exp_hi: 32'hFFFF_FFFE, exp_lo: 32'h0000_0001};
    vecs[2] = '{a: 32'h8000_0000,  b: 32'd2,          exp_hi: 32'h0000_0001, exp_lo: 32'h0000_0000};
    vecs[3] = '{a: 32'd0,          b: 32'h1234_5678,  exp_hi: 32'h0000_0000, exp_lo: 32'h0000_0000};
    vecs[4] = '{a: 32'hDEAD_BEEF,  b: 32'd1,          exp_hi: 32'h0000_0000, exp_lo: 32'hDEAD_BEEF};

    reset = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset.hilo", {hi, lo}, 64'd0);
    chk("reset.busy_done", {62'd0, busy, done}, 64'd0);
    chk("reset.adder", {add_op1, add_op2}, 64'd0);

    for (int i = 0; i < 5; i++) begin
      run(vecs[i].a, vecs[i].b, 1'b0, lat);
      finish_checks($sformatf("vec%0d", i), lat, {vecs[i].exp_hi, vecs[i].exp_lo});
      hold_checks($sformatf("vec%0d", i), {vecs[i].exp_hi, vecs[i].exp_lo});
    end

    // Starts pulsed mid-run with other operands must not disturb the result.
    run(32'd3, 32'd5, 1'b1, lat);
    finish_checks("ignore_start", lat, 64'd15);
    hold_checks("ignore_start", 64'd15);

    // Back-to-back: new start presented while done is high.
    run(32'h8000_0000, 32'd2, 1'b0, lat);
    finish_checks("b2b_first", lat, 64'h1_0000_0000);
    run(32'd7, 32'd6, 1'b0, lat);
    finish_checks("b2b_second", lat, 64'd42);
    hold_checks("b2b_second", 64'd42);

    // Reset in the middle of a run: outputs clear asynchronously, no done follows.
    start = 1'b1;
    op_a  = 32'h1234;
    op_b  = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset.busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midreset.busy_done", {62'd0, busy, done}, 64'd0);
    chk("midreset.hilo", {hi, lo}, 64'd0);
    chk("midreset.adder", {add_op1, add_op2}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("midreset.no_done", 64'(done_cnt), 64'd0);
    run(32'h0001_0000, 32'h0001_0000, 1'b0, lat);
    finish_checks("post_reset", lat, 64'h1_0000_0000);
    hold_checks("post_reset", 64'h1_0000_0000);

    // Random operands against the exact 64-bit product.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 0) ra = 32'hFFFF_FFFF;
      exp = 64'(ra) * 64'(rb);
      run(ra, rb, $urandom_range(0, 1) == 1, lat);
      finish_checks($sformatf("rand%0d", i), lat, exp);
      if ($urandom_range(0, 1) == 1) hold_checks($sformatf("rand%0d", i), exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
